exec_sequencer: RTL and testbench

Multi-cycle execute/writeback sequencer for the 4 x n-bit general-purpose register file. It accepts one instruction word per handshake, reads source operands through the register file's two combinational read ports, computes an ALU result, and writes it back through the register file's single write port. It also maintains zero/carry flags. It sits between instruction fetch and the register file, driving every register-file port.

---
 rtl/exec_sequencer.sv | 143 ++++++++++++++
 tb/tb_exec_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Execute/writeback sequencer for a 4-entry register file: fetch handshake,
// operand read, single-cycle ALU, write-back, and zero/carry flag upkeep.
module exec_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] instr_data,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [1:0]   rd0_num,
  output logic [1:0]   rd1_num,
  input  logic [N-1:0] rd0_data,
  input  logic [N-1:0] rd1_data,
  output logic [N-1:0] wr_data,
  output logic [1:0]   wr_num,
  output logic         wr_en,
  output logic         flag_z,
  output logic         flag_c,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_IMM, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_MOV = 4'd8, OP_LDI = 4'd9;

  state_t         state_q, state_d;
  logic [7:0]     ir_q, ir_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic           z_q, z_d, c_q, c_d;

  logic [3:0]     op_s;
  logic           accept_s;
  logic [N:0]     sum_s, diff_s;
  logic [N-1:0]   alu_r_s;
  logic           alu_c_s;

  assign op_s     = ir_q[7:4];
  assign accept_s = instr_valid & instr_ready;
  // The top bit of an (N+1)-bit difference is the unsigned borrow.
  assign sum_s    = {1'b0, a_q} + {1'b0, b_q};
  assign diff_s   = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_r_s = r_q;
    alu_c_s = c_q;
    case (op_s)
      OP_ADD:  begin alu_r_s = sum_s[N-1:0];  alu_c_s = sum_s[N];  end
      OP_SUB:  begin alu_r_s = diff_s[N-1:0]; alu_c_s = diff_s[N]; end
      OP_AND:  begin alu_r_s = a_q & b_q;     alu_c_s = 1'b0;      end
      OP_OR:   begin alu_r_s = a_q | b_q;     alu_c_s = 1'b0;      end
      OP_XOR:  begin alu_r_s = a_q ^ b_q;     alu_c_s = 1'b0;      end
      OP_NOT:  begin alu_r_s = ~a_q;          alu_c_s = 1'b0;      end
      OP_SHL:  begin alu_r_s = {a_q[N-2:0], 1'b0}; alu_c_s = a_q[N-1]; end
      OP_SHR:  begin alu_r_s = {1'b0, a_q[N-1:1]}; alu_c_s = a_q[0];   end
      OP_MOV:  begin alu_r_s = b_q;           alu_c_s = c_q;       end
      default: begin alu_r_s = r_q;           alu_c_s = c_q;       end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ir_d    = instr_data[7:0];
          state_d = (instr_data[7:4] == OP_LDI) ? S_IMM : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IMM: begin
        if (accept_s) begin
          r_d     = instr_data;
          state_d = S_WB;
        end else begin
          state_d = S_IMM;
        end
      end
      S_READ: begin
        a_d     = rd0_data;
        b_d     = rd1_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        r_d = alu_r_s;
        // Only the ALU ops 0-7 touch the flags; MOV and NOP preserve them.
        if (op_s <= OP_SHR) begin
          z_d = (alu_r_s == {N{1'b0}});
          c_d = alu_c_s;
        end else begin
          z_d = z_q;
          c_d = c_q;
        end
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= 8'd0;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      r_q     <= {N{1'b0}};
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Outputs decode registered state only, so reset clears wr_en at once.
  assign instr_ready = (state_q == S_IDLE) || (state_q == S_IMM);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_WB);
  assign wr_en       = (state_q == S_WB) && (op_s <= OP_LDI);
  assign wr_num      = (state_q == S_WB) ? ir_q[3:2] : 2'd0;
  assign wr_data     = (state_q == S_WB) ? r_q : {N{1'b0}};
  assign rd0_num     = ir_q[3:2];
  assign rd1_num     = ir_q[1:0];
  assign flag_z      = z_q;
  assign flag_c      = c_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed vector table, hand-written corner
// sequences, and random instructions checked against an arithmetic model.
module tb_exec_sequencer;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] instr_data;
  logic         instr_valid;
  logic         instr_ready;
  logic [1:0]   rd0_num, rd1_num;
  logic [N-1:0] rd0_data, rd1_data;
  logic [N-1:0] wr_data;
  logic [1:0]   wr_num;
  logic         wr_en, flag_z, flag_c, done, busy;

  exec_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rd0_num(rd0_num), .rd1_num(rd1_num),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .wr_data(wr_data), .wr_num(wr_num),
    .wr_en(wr_en), .flag_z(flag_z), .flag_c(flag_c), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side register file: combinational reads, write on the WB-ending edge.
  logic [7:0] rf [4];
  assign rd0_data = rf[rd0_num];
  assign rd1_data = rf[rd1_num];
  always @(posedge clk) if (wr_en) rf[wr_num] <= wr_data;

  int errors = 0;
  int checks = 0;

  // Reference architectural state.
  logic [7:0] model_rf [4];
  logic       mz = 1'b0;
  logic       mc = 1'b0;

  typedef struct {
    logic [7:0] w;
    logic [7:0] imm;
    logic       we;
    logic [7:0] d;
    logic       z;
    logic       c;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one instruction, computed with plain integers.
  task automatic model_step(input logic [7:0] w, input logic [7:0] imm,
                            output logic we, output logic [7:0] d,
                            output logic z, output logic c);
    int a, b, res, op;
    op  = int'(w[7:4]);
    a   = int'(model_rf[w[3:2]]);
    b   = int'(model_rf[w[1:0]]);
    we  = 1'b1;
    z   = mz;
    c   = mc;
    res = 0;
    case (op)
      0: begin res = a + b; c = (res > 255); res = res % 256; end
      1: begin res = a - b; c = (a < b); if (res < 0) res = res + 256; end
      2: begin res = a & b; c = 1'b0; end
      3: begin res = a | b; c = 1'b0; end
      4: begin res = a ^ b; c = 1'b0; end
      5: begin res = 255 - a; c = 1'b0; end
      6: begin res = (a * 2) % 256; c = (a >= 128); end
      7: begin res = a / 2; c = ((a % 2) == 1); end
      8: res = b;
      9: res = int'(imm);
      default: we = 1'b0;
    endcase
    d = 8'(res);
    if (op <= 7) z = (d == 8'd0);
    if (we) model_rf[w[3:2]] = d;
    mz = z;
    mc = c;
  endtask

  // Issue one instruction from IDLE and check its cycle-by-cycle behaviour.
  task automatic run_instr(input logic [7:0] w, input logic [7:0] imm, input logic exp_we,
                           input logic [7:0] exp_d, input logic exp_z, input logic exp_c);
    chk("ready_in_idle", 32'(instr_ready), 32'd1);
    instr_data  = w;
    instr_valid = 1'b1;
    tick();
    if (w[7:4] == 4'd9) begin
      chk("imm_ready", 32'(instr_ready), 32'd1);
      chk("imm_busy", 32'(busy), 32'd1);
      instr_data = imm;
      tick();
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
    end else begin
      // An LDI offered while busy must be ignored.
      instr_data = 8'h9F;
      chk("read_ready", 32'(instr_ready), 32'd0);
      chk("read_done", 32'(done), 32'd0);
      tick();
      chk("exec_done", 32'(done), 32'd0);
      chk("exec_ready", 32'(instr_ready), 32'd0);
      tick();
      instr_valid = 1'b0;
    end
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_wr_en", 32'(wr_en), 32'(exp_we));
    if (exp_we) begin
      chk("wb_wr_num", 32'(wr_num), 32'(w[3:2]));
      chk("wb_wr_data", 32'(wr_data), 32'(exp_d));
    end
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_wr_en", 32'(wr_en), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("flag_z", 32'(flag_z), 32'(exp_z));
    chk("flag_c", 32'(flag_c), 32'(exp_c));
  endtask

  initial begin
    logic       we, z, c;
    logic [7:0] d, w, imm;

    tbl[0]  = '{8'h94, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0};
    tbl[1]  = '{8'h98, 8'h03, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[2]  = '{8'h06, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0};
    tbl[3]  = '{8'h94, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4]  = '{8'h98, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[5]  = '{8'h06, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[6]  = '{8'h1A, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{8'h98, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[8]  = '{8'h16, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1};
    tbl[9]  = '{8'h9C, 8'h81, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[10] = '{8'h6C, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1};
    tbl[11] = '{8'h9C, 8'h81, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[12] = '{8'h7C, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1};
    tbl[13] = '{8'h83, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1};
    tbl[14] = '{8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[15] = '{8'h2C, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0};
    tbl[16] = '{8'h4F, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[17] = '{8'h5C, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[18] = '{8'h33, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[19] = '{8'hF0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_num", 32'(wr_num), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd0_num", 32'(rd0_num), 32'd0);
    chk("rst_rd1_num", 32'(rd1_num), 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_flag_c", 32'(flag_c), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      model_step(tbl[i].w, tbl[i].imm, we, d, z, c);
      run_instr(tbl[i].w, tbl[i].imm, tbl[i].we, tbl[i].d, tbl[i].z, tbl[i].c);
    end

    // LDI r2 whose immediate arrives after five idle cycles.
    instr_data  = 8'h98;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("imm_hold_ready", 32'(instr_ready), 32'd1);
      chk("imm_hold_busy", 32'(busy), 32'd1);
      chk("imm_hold_done", 32'(done), 32'd0);
      tick();
    end
    model_step(8'h98, 8'h3C, we, d, z, c);
    instr_data  = 8'h3C;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("imm_late_done", 32'(done), 32'd1);
    chk("imm_late_wr_en", 32'(wr_en), 32'd1);
    chk("imm_late_wr_num", 32'(wr_num), 32'd2);
    chk("imm_late_wr_data", 32'(wr_data), 32'h3C);
    tick();
    chk("imm_late_idle", 32'(busy), 32'd0);

    // Reset during EXEC of ADD r1,r2 must abort with no write-back.
    instr_data  = 8'h06;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_flag_z", 32'(flag_z), 32'd0);
    chk("abort_flag_c", 32'(flag_c), 32'd0);
    tick();
    rst_n = 1'b1;
    mz = 1'b0;
    mc = 1'b0;
    tick();
    chk("abort_no_write", 32'(rf[1]), 32'(model_rf[1]));
    model_step(8'h06, 8'h00, we, d, z, c);
    run_instr(8'h06, 8'h00, we, d, z, c);

    // Random instructions against the model, registers seeded first.
    for (int r = 0; r < 4; r++) begin
      w   = {4'd9, 2'(r), 2'd0};
      imm = 8'($urandom);
      model_step(w, imm, we, d, z, c);
      run_instr(w, imm, we, d, z, c);
    end
    for (int i = 0; i < 150; i++) begin
      w   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) w[7:4] = 4'd9;
      else if ($urandom_range(0, 3) != 0) w[7:4] = 4'($urandom_range(0, 8));
      imm = 8'($urandom);
      model_step(w, imm, we, d, z, c);
      run_instr(w, imm, we, d, z, c);
    end
    for (int r = 0; r < 4; r++) chk("final_rf", 32'(rf[r]), 32'(model_rf[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
